ex_muldiv_ctrl: RTL and testbench

Iterative multiply/divide sequencer for the EX stage. When the instruction held in ID/EX is an M-extension op, it takes the operands, runs a 32-step shift-add multiply or restoring divide, and stalls the front of the pipeline until done. It then presents the result for one cycle alongside the normal ALU result, so EX/MEM captures it in place of `alu_result`. Sits beside the EX-stage ALU, fed from the same ID/EX register outputs.

---
 rtl/ex_muldiv_ctrl.sv | 164 ++++++++++++++++
 tb/tb_ex_muldiv_ctrl.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv_ctrl.sv
// ex_muldiv_ctrl: iterative unsigned multiply/divide sequencer for the EX stage.
// It runs a 32-step shift-add multiply or a restoring divide. It holds the front
// of the pipeline while the op runs, then pulses result_valid for one cycle so
// EX/MEM captures the result.
module ex_muldiv_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] rdata1,
    input  logic [31:0] rdata2,
    input  logic [4:0]  rd_in,
    input  logic        flush,
    output logic        stall,
    output logic        busy,
    output logic        result_valid,
    output logic [31:0] result,
    output logic [4:0]  rd_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_reg, state_next;
    logic [1:0]  op_reg;
    logic [31:0] a_reg;        // multiplicand
    logic [31:0] b_reg;        // divisor
    logic [4:0]  rd_reg;
    logic [63:0] acc_reg;      // {product high, product low / remaining multiplier bits}
    logic [31:0] rem_reg;
    logic [31:0] quot_reg;
    logic [4:0]  count_reg;
    logic [31:0] result_reg;
    logic [4:0]  rd_out_reg;

    logic        accept;
    logic        div_by_zero;
    logic [32:0] mul_sum;
    logic [63:0] mul_acc_next;
    logic [32:0] div_shift;
    logic [32:0] div_diff;
    logic        div_ge;
    logic [31:0] div_rem_next;
    logic [31:0] div_quot_next;
    logic [31:0] calc_result;

    assign accept      = start & ~flush;
    assign div_by_zero = op[1] & (rdata2 == 32'd0);

    // One multiply step. The low half of the accumulator starts out holding
    // the multiplier, and its bits are consumed from the LSB as product bits
    // shift in from above.
    assign mul_sum      = {1'b0, acc_reg[63:32]} + {1'b0, (acc_reg[0] ? a_reg : 32'd0)};
    assign mul_acc_next = {mul_sum, acc_reg[31:1]};

    // One restoring-divide step. rem < divisor always holds, so the shifted
    // remainder fits in 33 bits. A borrow out of bit 32 means "less than divisor".
    assign div_shift     = {rem_reg, quot_reg[31]};
    assign div_diff      = div_shift - {1'b0, b_reg};
    assign div_ge        = ~div_diff[32];
    assign div_rem_next  = div_ge ? div_diff[31:0] : div_shift[31:0];
    assign div_quot_next = {quot_reg[30:0], div_ge};

    // Select the result that the final step produces.
    always_comb begin
        calc_result = 32'd0;
        case (op_reg)
            2'b00:   calc_result = mul_acc_next[31:0];
            2'b01:   calc_result = mul_acc_next[63:32];
            2'b10:   calc_result = div_quot_next;
            default: calc_result = div_rem_next;
        endcase
    end

    // Next-state logic. flush beats start. DONE always returns to IDLE.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next = div_by_zero ? DONE : CALC;
                end
            end
            CALC: begin
                if (flush) begin
                    state_next = IDLE;
                end else if (count_reg == 5'd31) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Operand latch, iteration datapath, and the result/rd_out holding registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_reg     <= 2'd0;
            a_reg      <= 32'd0;
            b_reg      <= 32'd0;
            rd_reg     <= 5'd0;
            acc_reg    <= 64'd0;
            rem_reg    <= 32'd0;
            quot_reg   <= 32'd0;
            count_reg  <= 5'd0;
            result_reg <= 32'd0;
            rd_out_reg <= 5'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        op_reg    <= op;
                        a_reg     <= rdata1;
                        b_reg     <= rdata2;
                        rd_reg    <= rd_in;
                        acc_reg   <= {32'd0, rdata2};
                        rem_reg   <= 32'd0;
                        quot_reg  <= rdata1;
                        count_reg <= 5'd0;
                        if (div_by_zero) begin
                            result_reg <= op[0] ? rdata1 : 32'hFFFF_FFFF;
                            rd_out_reg <= rd_in;
                        end
                    end
                end
                CALC: begin
                    count_reg <= count_reg + 5'd1;
                    if (op_reg[1]) begin
                        rem_reg  <= div_rem_next;
                        quot_reg <= div_quot_next;
                    end else begin
                        acc_reg <= mul_acc_next;
                    end
                    if (state_next == DONE) begin
                        result_reg <= calc_result;
                        rd_out_reg <= rd_reg;
                    end
                end
                default: ;
            endcase
        end
    end

    // Handshake outputs. They are forced low while reset is held.
    assign stall        = ~rst & (((state_reg == IDLE) & accept) | (state_reg == CALC));
    assign busy         = ~rst & (state_reg == CALC);
    assign result_valid = ~rst & (state_reg == DONE) & ~flush;
    assign result       = result_reg;
    assign rd_out       = rd_out_reg;

endmodule

// File: tb/tb_ex_muldiv_ctrl.sv
// tb_ex_muldiv_ctrl: directed test of the EX-stage mul/div sequencer.
module tb_ex_muldiv_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rdata1;
    logic [31:0] rdata2;
    logic [4:0]  rd_in;
    logic        flush;
    logic        stall;
    logic        busy;
    logic        result_valid;
    logic [31:0] result;
    logic [4:0]  rd_out;

    int checks = 0;
    int errors = 0;

    ex_muldiv_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .op           (op),
        .rdata1       (rdata1),
        .rdata2       (rdata2),
        .rd_in        (rd_in),
        .flush        (flush),
        .stall        (stall),
        .busy         (busy),
        .result_valid (result_valid),
        .result       (result),
        .rd_out       (rd_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
        $display("check %-22s observed %h expected %h", tag, obs, exp);
    endtask

    // Issue one op at a negedge and follow it until its result_valid pulse.
    // The op ends at the negedge of the first IDLE cycle after DONE, which
    // lets the next call issue back-to-back.
    task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd,
                         input logic [31:0] exp_res, input int exp_lat);
        int cyc;
        int stl;
        op     = o;
        rdata1 = a;
        rdata2 = b;
        rd_in  = rd;
        flush  = 1'b0;
        start  = 1'b1;
        cyc    = 0;
        stl    = 0;
        #1;
        while (!result_valid && cyc < 100) begin
            if (stall) stl++;
            @(negedge clk);
            cyc++;
        end
        chk({tag, " latency"}, cyc, exp_lat);
        chk({tag, " stall_cycles"}, stl, exp_lat);
        chk({tag, " result"}, result, exp_res);
        chk({tag, " rd_out"}, rd_out, {27'd0, rd});
        chk({tag, " stall_in_done"}, stall, 0);
        chk({tag, " busy_in_done"}, busy, 0);
        @(negedge clk);
        start = 1'b0;
        #1;
        chk({tag, " valid_pulse_end"}, result_valid, 0);
        chk({tag, " result_hold"}, result, exp_res);
        chk({tag, " idle_stall"}, stall, 0);
    endtask

    initial begin
        int seen_valid;
        rst    = 1'b1;
        start  = 1'b1;
        op     = 2'b00;
        rdata1 = 32'd3;
        rdata2 = 32'd4;
        rd_in  = 5'd1;
        flush  = 1'b0;

        // Reset state while start is also high.
        @(negedge clk);
        chk("rst stall", stall, 0);
        chk("rst busy", busy, 0);
        chk("rst result_valid", result_valid, 0);
        chk("rst result", result, 0);
        chk("rst rd_out", rd_out, 0);
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);

        // Multiply, divide, and divide-by-zero ops, each issued right after the previous one.
        do_op("mul7x6",   2'b00, 32'd7,          32'd6,          5'd5,  32'd42,         33);
        do_op("mulhu_ff", 2'b01, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd6,  32'hFFFF_FFFE,  33);
        do_op("mul_ff",   2'b00, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd7,  32'h0000_0001,  33);
        do_op("divu100_7",2'b10, 32'd100,        32'd7,          5'd8,  32'd14,         33);
        do_op("remu100_7",2'b11, 32'd100,        32'd7,          5'd9,  32'd2,          33);
        do_op("divu_by0", 2'b10, 32'd1234,       32'd0,          5'd10, 32'hFFFF_FFFF,  1);
        do_op("remu_by0", 2'b11, 32'd1234,       32'd0,          5'd11, 32'd1234,       1);

        // Flush a MUL when its counter reaches 10.
        op     = 2'b00;
        rdata1 = 32'd3;
        rdata2 = 32'd5;
        rd_in  = 5'd12;
        start  = 1'b1;
        repeat (11) @(negedge clk);
        chk("flush busy_before", busy, 1);
        flush = 1'b1;
        @(negedge clk);
        chk("flush stall_after", stall, 0);
        chk("flush busy_after", busy, 0);
        start = 1'b0;
        flush = 1'b0;
        seen_valid = 0;
        repeat (40) begin
            @(negedge clk);
            if (result_valid) seen_valid++;
        end
        chk("flush no_valid", seen_valid, 0);
        chk("flush result_kept", result, 32'd1234);
        chk("flush rd_out_kept", rd_out, 32'd11);

        // Reset in the middle of a DIVU.
        op     = 2'b10;
        rdata1 = 32'd1000;
        rdata2 = 32'd3;
        rd_in  = 5'd9;
        start  = 1'b1;
        repeat (5) @(negedge clk);
        chk("midrst busy_before", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst stall", stall, 0);
        chk("midrst busy", busy, 0);
        chk("midrst result_valid", result_valid, 0);
        chk("midrst result", result, 0);
        chk("midrst rd_out", rd_out, 0);
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        do_op("mul_after_rst", 2'b00, 32'd12345, 32'd1000, 5'd3, 32'd12345000, 33);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
